// File: rtl/mm_seq_ctrl.sv
// mm_seq_ctrl: Wishbone-programmable sequencer for C = A x B on NxN matrices.
// Walks the i/j/k loop nest and drives operand reads, MAC strobes and result writes.
module mm_seq_ctrl #(
  parameter int          LOGN      = 2,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              rd_en,
  output logic [2*LOGN-1:0] a_addr,
  output logic [2*LOGN-1:0] b_addr,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              res_we,
  output logic [2*LOGN-1:0] res_addr,
  output logic              irq
);
  localparam int              AW       = 2*LOGN;
  localparam logic [LOGN-1:0] LAST_IDX = {LOGN{1'b1}};

  typedef enum logic [2:0] {IDLE, CLR, ISSUE, DRAIN, WR} state_t;

  state_t          state_reg, state_next;
  logic [LOGN-1:0] i_reg, i_next, j_reg, j_next, k_reg, k_next;
  logic            irq_en_reg, irq_en_next;
  logic            done_reg, done_next;
  logic            aborted_reg, aborted_next;
  logic [15:0]     cycles_reg, cycles_next;

  // Bus request is captured on select and acted upon during the ack cycle.
  logic            ack_reg;
  logic [31:0]     dat_reg;
  logic            req_we_reg, req_sel0_reg;
  logic [1:0]      req_off_reg;
  logic [2:0]      req_dat_reg;
  logic            sel_hit, accept;
  logic [31:0]     rdata;
  logic            wr_ctrl, wr_status, abort_req, last_elem;

  logic            rd_en_reg, rd_en_next;
  logic            mac_clr_reg, mac_clr_next;
  logic            mac_en_reg;
  logic            res_we_reg, res_we_next;
  logic            irq_reg, irq_next;
  logic [AW-1:0]   a_addr_reg, a_addr_next;
  logic [AW-1:0]   b_addr_reg, b_addr_next;
  logic [AW-1:0]   res_addr_reg, res_addr_next;

  logic            unused_bits;
  assign unused_bits = ^{wbs_adr_i[1:0], wbs_sel_i[3:1], wbs_dat_i[31:3]};

  assign sel_hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign accept  = sel_hit & ~ack_reg;

  always_comb begin
    rdata = '0;
    case (wbs_adr_i[3:2])
      2'd0:    rdata[1]    = irq_en_reg;
      2'd1:    rdata[2:0]  = {aborted_reg, done_reg, state_reg != IDLE};
      2'd2:    rdata[15:0] = cycles_reg;
      default: rdata       = '0;
    endcase
  end

  assign wr_ctrl   = ack_reg & req_we_reg & req_sel0_reg & (req_off_reg == 2'd0);
  assign wr_status = ack_reg & req_we_reg & req_sel0_reg & (req_off_reg == 2'd1);
  assign abort_req = wr_ctrl & req_dat_reg[2] & (state_reg != IDLE);
  assign last_elem = (i_reg == LAST_IDX) && (j_reg == LAST_IDX);

  always_comb begin
    state_next   = state_reg;
    i_next       = i_reg;
    j_next       = j_reg;
    k_next       = k_reg;
    irq_en_next  = irq_en_reg;
    done_next    = done_reg;
    aborted_next = aborted_reg;
    cycles_next  = cycles_reg;

    if (state_reg != IDLE && cycles_reg != 16'hFFFF)
      cycles_next = cycles_reg + 16'd1;
    if (wr_ctrl)
      irq_en_next = req_dat_reg[1];
    // W1C is applied first so a same-cycle completion still sets DONE.
    if (wr_status) begin
      if (req_dat_reg[1]) done_next    = 1'b0;
      if (req_dat_reg[2]) aborted_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (wr_ctrl && req_dat_reg[0] && !req_dat_reg[2]) begin
          state_next   = CLR;
          i_next       = '0;
          j_next       = '0;
          k_next       = '0;
          done_next    = 1'b0;
          aborted_next = 1'b0;
          cycles_next  = '0;
        end
      end
      CLR:   state_next = ISSUE;
      ISSUE: begin
        k_next = k_reg + 1'b1;
        if (k_reg == LAST_IDX) state_next = DRAIN;
      end
      DRAIN: state_next = WR;
      WR: begin
        if (j_reg == LAST_IDX) begin
          j_next = '0;
          i_next = i_reg + 1'b1;
        end else begin
          j_next = j_reg + 1'b1;
        end
        if (last_elem) begin
          state_next = IDLE;
          if (!abort_req) done_next = 1'b1;
        end else begin
          state_next = CLR;
        end
      end
      default: state_next = IDLE;
    endcase

    if (abort_req) begin
      state_next   = IDLE;
      aborted_next = 1'b1;
    end
  end

  // Outputs are registered from the next-state view so they line up with the state.
  always_comb begin
    rd_en_next    = (state_next == ISSUE);
    mac_clr_next  = (state_next == CLR);
    res_we_next   = (state_next == WR);
    a_addr_next   = rd_en_next  ? {i_next, k_next} : '0;
    b_addr_next   = rd_en_next  ? {k_next, j_next} : '0;
    res_addr_next = res_we_next ? {i_next, j_next} : '0;
    irq_next      = done_next & irq_en_next;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg    <= IDLE;
      i_reg        <= '0;
      j_reg        <= '0;
      k_reg        <= '0;
      irq_en_reg   <= 1'b0;
      done_reg     <= 1'b0;
      aborted_reg  <= 1'b0;
      cycles_reg   <= '0;
      ack_reg      <= 1'b0;
      dat_reg      <= '0;
      req_we_reg   <= 1'b0;
      req_sel0_reg <= 1'b0;
      req_off_reg  <= '0;
      req_dat_reg  <= '0;
      rd_en_reg    <= 1'b0;
      mac_clr_reg  <= 1'b0;
      mac_en_reg   <= 1'b0;
      res_we_reg   <= 1'b0;
      irq_reg      <= 1'b0;
      a_addr_reg   <= '0;
      b_addr_reg   <= '0;
      res_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      i_reg        <= i_next;
      j_reg        <= j_next;
      k_reg        <= k_next;
      irq_en_reg   <= irq_en_next;
      done_reg     <= done_next;
      aborted_reg  <= aborted_next;
      cycles_reg   <= cycles_next;
      ack_reg      <= accept;
      dat_reg      <= (accept && !wbs_we_i) ? rdata : '0;
      if (accept) begin
        req_we_reg   <= wbs_we_i;
        req_sel0_reg <= wbs_sel_i[0];
        req_off_reg  <= wbs_adr_i[3:2];
        req_dat_reg  <= wbs_dat_i[2:0];
      end
      rd_en_reg    <= rd_en_next;
      mac_clr_reg  <= mac_clr_next;
      mac_en_reg   <= rd_en_reg;
      res_we_reg   <= res_we_next;
      irq_reg      <= irq_next;
      a_addr_reg   <= a_addr_next;
      b_addr_reg   <= b_addr_next;
      res_addr_reg <= res_addr_next;
    end
  end

  assign wbs_ack_o = ack_reg;
  assign wbs_dat_o = dat_reg;
  assign rd_en     = rd_en_reg;
  assign a_addr    = a_addr_reg;
  assign b_addr    = b_addr_reg;
  assign mac_clr   = mac_clr_reg;
  assign mac_en    = mac_en_reg;
  assign res_we    = res_we_reg;
  assign res_addr  = res_addr_reg;
  assign irq       = irq_reg;
endmodule

// File: tb/tb_mm_seq_ctrl.sv
// tb_mm_seq_ctrl: self-checking bench for mm_seq_ctrl against a cycle-table model
// derived from the per-element schedule of the matrix-multiply loop nest.
`timescale 1ns/1ps
module tb_mm_seq_ctrl;
  localparam int          LOGN = 2;
  localparam int          N    = 1 << LOGN;
  localparam int          RUN  = N*N*(N+3);
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i = 1'b1;
  logic              wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]        wbs_sel_i = 4'h0;
  logic [31:0]       wbs_adr_i = 32'h0, wbs_dat_i = 32'h0;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic              rd_en, mac_clr, mac_en, res_we, irq;
  logic [2*LOGN-1:0] a_addr, b_addr, res_addr;

  mm_seq_ctrl #(.LOGN(LOGN), .BASE_ADDR(BASE)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .rd_en(rd_en), .a_addr(a_addr), .b_addr(b_addr),
    .mac_clr(mac_clr), .mac_en(mac_en), .res_we(res_we), .res_addr(res_addr),
    .irq(irq)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int cnt = 0;
  always @(posedge wb_clk_i) cnt <= cnt + 1;

  int tests = 0;
  int fails = 0;

  // Expected strobes/addresses indexed by cycles after the START ack cycle.
  bit                e_rd  [0:RUN+1];
  bit                e_clr [0:RUN+1];
  bit                e_en  [0:RUN+1];
  bit                e_we  [0:RUN+1];
  logic [2*LOGN-1:0] e_a   [0:RUN+1];
  logic [2*LOGN-1:0] e_b   [0:RUN+1];
  logic [2*LOGN-1:0] e_r   [0:RUN+1];

  task automatic build_model();
    for (int d = 0; d <= RUN+1; d++) begin
      e_rd[d] = 0; e_clr[d] = 0; e_en[d] = 0; e_we[d] = 0;
      e_a[d] = '0; e_b[d] = '0; e_r[d] = '0;
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        int base;
        base = 1 + (i*N + j)*(N+3);
        e_clr[base] = 1;
        for (int k = 0; k < N; k++) begin
          e_rd[base+1+k] = 1;
          e_a[base+1+k]  = (2*LOGN)'(i*N + k);
          e_b[base+1+k]  = (2*LOGN)'(k*N + j);
          e_en[base+2+k] = 1;
        end
        e_we[base+N+2] = 1;
        e_r[base+N+2]  = (2*LOGN)'(i*N + j);
      end
    end
  endtask

  task automatic step();
    @(posedge wb_clk_i); #1;
  endtask

  task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                         input logic [3:0] sel, output logic [31:0] rdat, output int lat);
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = wdat; wbs_sel_i = sel;
    lat = 0; rdat = 32'h0;
    for (int c = 1; c <= 16; c++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) begin
        lat = c;
        rdat = wbs_dat_o;
        break;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    $display("[TB] wb %s adr=%h wdat=%h rdat=%h ack_lat=%0d", we ? "wr" : "rd", adr, wdat, rdat, lat);
  endtask

  task automatic wb_write(input int off, input logic [31:0] dat, input logic [3:0] sel,
                          output int t_ack, output int lat);
    logic [31:0] dummy;
    wb_xfer(BASE + 32'(off*4), 1'b1, dat, sel, dummy, lat);
    t_ack = cnt;
  endtask

  task automatic wb_read(input int off, output logic [31:0] d, output int lat);
    wb_xfer(BASE + 32'(off*4), 1'b0, 32'h0, 4'hF, d, lat);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int lat;
    wb_rst_i = 1'b1;
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i); wb_rst_i = 1'b0;
    step();
    tests++;
    if ({wbs_ack_o, rd_en, mac_clr, mac_en, res_we, irq} !== 6'b0) begin
      fails++; $display("FAIL reset_strobes got=%b exp=000000", {wbs_ack_o, rd_en, mac_clr, mac_en, res_we, irq});
    end
    tests++;
    if ({wbs_dat_o, a_addr, b_addr, res_addr} !== '0) begin
      fails++; $display("FAIL reset_data got dat=%h a=%0d b=%0d r=%0d exp=0", wbs_dat_o, a_addr, b_addr, res_addr);
    end
    for (int off = 0; off < 3; off++) begin
      wb_read(off, d, lat);
      tests++;
      if (d !== 32'h0) begin fails++; $display("FAIL reset_read off=%0d got=%h exp=0", off, d); end
      tests++;
      if (lat != 1) begin fails++; $display("FAIL reset_ack_lat off=%0d got=%0d exp=1", off, lat); end
    end
  endtask

  task automatic test_window();
    logic [31:0] d;
    int lat, t, seen;
    wb_xfer(BASE + 32'h20, 1'b0, 32'h0, 4'hF, d, lat);
    tests++;
    if (lat != 0) begin fails++; $display("FAIL oow_ack got_lat=%0d exp=no ack", lat); end
    wb_write(0, 32'h3, 4'b1110, t, lat);
    tests++;
    if (lat != 1) begin fails++; $display("FAIL sel_ack got_lat=%0d exp=1", lat); end
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (rd_en || mac_clr || res_we) seen++;
    end
    tests++;
    if (seen != 0) begin fails++; $display("FAIL sel_no_run got_active=%0d exp=0", seen); end
    wb_read(0, d, lat);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL sel_ctrl got=%h exp=0", d); end
  endtask

  task automatic test_start_abort_same();
    logic [31:0] d;
    int lat, t, seen;
    wb_write(0, 32'h5, 4'h1, t, lat);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (rd_en || mac_clr || res_we) seen++;
    end
    tests++;
    if (seen != 0) begin fails++; $display("FAIL start_abort_run got_active=%0d exp=0", seen); end
    wb_write(0, 32'h4, 4'h1, t, lat);
    wb_read(1, d, lat);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL idle_abort_status got=%h exp=0", d); end
  endtask

  task automatic test_back_to_back();
    int acks, dbl;
    bit prev;
    acks = 0; dbl = 0; prev = 0;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = BASE + 32'h4; wbs_sel_i = 4'hF;
    for (int c = 0; c < 6; c++) begin
      step();
      if (wbs_ack_o && prev) dbl++;
      if (wbs_ack_o) acks++;
      prev = wbs_ack_o;
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    $display("[TB] wb rd held 6 cycles adr=%h acks=%0d", BASE + 32'h4, acks);
    tests++;
    if (dbl != 0) begin fails++; $display("FAIL ack_consecutive got=%0d exp=0", dbl); end
    tests++;
    if (acks != 3) begin fails++; $display("FAIL ack_count got=%0d exp=3", acks); end
  endtask

  task automatic test_full_run(input bit ien);
    logic [31:0] d;
    int lat, t0;
    wb_write(0, {30'b0, ien, 1'b1}, 4'h1, t0, lat);
    tests++;
    if (lat != 1) begin fails++; $display("FAIL run_start_ack got=%0d exp=1", lat); end
    for (int dd = 1; dd <= RUN+1; dd++) begin
      step();
      tests++;
      if ({rd_en, mac_clr, mac_en, res_we} !== {e_rd[dd], e_clr[dd], e_en[dd], e_we[dd]}) begin
        fails++;
        $display("FAIL run_strobes d=%0d got=%b exp=%b", dd,
                 {rd_en, mac_clr, mac_en, res_we}, {e_rd[dd], e_clr[dd], e_en[dd], e_we[dd]});
      end
      if (e_rd[dd]) begin
        tests++;
        if (a_addr !== e_a[dd] || b_addr !== e_b[dd]) begin
          fails++; $display("FAIL run_ab d=%0d got a=%0d b=%0d exp a=%0d b=%0d", dd, a_addr, b_addr, e_a[dd], e_b[dd]);
        end
      end
      if (e_we[dd]) begin
        tests++;
        if (res_addr !== e_r[dd]) begin
          fails++; $display("FAIL run_res_addr d=%0d got=%0d exp=%0d", dd, res_addr, e_r[dd]);
        end
      end
      tests++;
      if (irq !== ((dd == RUN+1) && ien)) begin
        fails++; $display("FAIL run_irq d=%0d got=%b exp=%b", dd, irq, (dd == RUN+1) && ien);
      end
    end
    wb_read(1, d, lat);
    tests++;
    if (d !== 32'h2) begin fails++; $display("FAIL run_status got=%h exp=2", d); end
    wb_read(2, d, lat);
    tests++;
    if (d !== 32'(RUN)) begin fails++; $display("FAIL run_cycles got=%0d exp=%0d", d, RUN); end
  endtask

  task automatic test_w1c();
    logic [31:0] d;
    int lat, t;
    wb_read(0, d, lat);
    tests++;
    if (d !== 32'h2) begin fails++; $display("FAIL w1c_ctrl_irq_en got=%h exp=2", d); end
    wb_write(1, 32'h2, 4'h1, t, lat);
    tests++;
    if (irq !== 1'b1) begin fails++; $display("FAIL w1c_irq_before got=%b exp=1", irq); end
    step();
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL w1c_irq_after got=%b exp=0", irq); end
    wb_read(1, d, lat);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL w1c_status got=%h exp=0", d); end
  endtask

  task automatic test_start_during_run();
    logic [31:0] d;
    int lat, t0, t1;
    wb_write(0, 32'h3, 4'h1, t0, lat);
    while (cnt < t0 + 30) step();
    wb_write(0, 32'h3, 4'h1, t1, lat);
    while (cnt < t0 + RUN) step();
    tests++;
    if (irq !== 1'b0 || res_we !== 1'b1) begin
      fails++; $display("FAIL restart_last_wr got irq=%b res_we=%b exp irq=0 res_we=1", irq, res_we);
    end
    step();
    tests++;
    if (irq !== 1'b1) begin fails++; $display("FAIL restart_irq got=%b exp=1", irq); end
    wb_read(2, d, lat);
    tests++;
    if (d !== 32'(RUN)) begin fails++; $display("FAIL restart_cycles got=%0d exp=%0d", d, RUN); end
  endtask

  task automatic test_abort(input int ab);
    logic [31:0] d;
    int lat, t0, t1, da;
    wb_write(0, 32'h3, 4'h1, t0, lat);
    while (cnt < t0 + ab - 2) step();
    wb_write(0, 32'h6, 4'h1, t1, lat);
    da = t1 - t0;
    step();
    tests++;
    if ({rd_en, mac_clr, res_we} !== 3'b0) begin
      fails++; $display("FAIL abort_strobes da=%0d got=%b exp=000", da, {rd_en, mac_clr, res_we});
    end
    tests++;
    if (mac_en !== e_rd[da]) begin fails++; $display("FAIL abort_mac_tail got=%b exp=%b", mac_en, e_rd[da]); end
    step();
    tests++;
    if (mac_en !== 1'b0 || irq !== 1'b0) begin
      fails++; $display("FAIL abort_quiet got mac_en=%b irq=%b exp 0 0", mac_en, irq);
    end
    wb_read(1, d, lat);
    tests++;
    if (d !== 32'h4) begin fails++; $display("FAIL abort_status got=%h exp=4", d); end
    wb_read(2, d, lat);
    tests++;
    if (d !== 32'(da)) begin fails++; $display("FAIL abort_cycles got=%0d exp=%0d", d, da); end
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL abort_irq got=%b exp=0", irq); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] d;
    int lat, t0;
    wb_write(0, 32'h3, 4'h1, t0, lat);
    while (cnt < t0 + 3) step();
    tests++;
    if (rd_en !== 1'b1) begin fails++; $display("FAIL midrst_issue got rd_en=%b exp=1", rd_en); end
    @(negedge wb_clk_i); wb_rst_i = 1'b1;
    step();
    tests++;
    if ({wbs_ack_o, rd_en, mac_clr, mac_en, res_we, irq, wbs_dat_o, a_addr, b_addr, res_addr} !== '0) begin
      fails++; $display("FAIL midrst_outputs got rd=%b clr=%b en=%b we=%b a=%0d b=%0d r=%0d exp all 0",
                        rd_en, mac_clr, mac_en, res_we, a_addr, b_addr, res_addr);
    end
    @(negedge wb_clk_i); wb_rst_i = 1'b0;
    wb_read(1, d, lat);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL midrst_status got=%h exp=0", d); end
    wb_read(0, d, lat);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL midrst_ctrl got=%h exp=0", d); end
  endtask

  initial begin
    build_model();
    test_reset();
    test_window();
    test_start_abort_same();
    test_back_to_back();
    test_full_run(1'b1);
    test_w1c();
    test_full_run(1'($urandom_range(0, 1)));
    test_start_during_run();
    test_abort(40);
    test_full_run(1'b1);
    test_abort(int'($urandom_range(20, 100)));
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mm_seq_ctrl.md
# mm_seq_ctrl

Wishbone-programmable sequencer for the matrix-multiply datapath inside the user project. It owns the loop nest for C = A × B on N×N matrices. It drives operand-buffer read addresses, MAC clear/enable strobes and result-buffer write strobes, and reports completion through a status register and a user IRQ line. It sits between the management SoC Wishbone slave port and the MAC/buffer datapath, and is the only block that starts or stops a multiply.

## Interface

Parameters:
- LOGN, 2: log2 of matrix dimension; N = 1<<LOGN (default N=4).
- BASE_ADDR, 32'h3000_0000: Wishbone window base; window is BASE_ADDR[31:4], 16 bytes.

Ports:
- wb_clk_i  in  1  sole clock; all logic rising-edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic cycle, strobe, write.
- wbs_sel_i  in  4  byte selects; only byte 0 is honoured for writes.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  single-cycle acknowledge.
- wbs_dat_o  out  32  read data, valid with ack, 0 otherwise.
- rd_en  out  1  operand-buffer read strobe.
- a_addr, b_addr  out  2*LOGN  A/B element addresses, row-major.
- mac_clr  out  1  clear accumulator.
- mac_en  out  1  accumulate current operands.
- res_we  out  1  write accumulator to result buffer.
- res_addr  out  2*LOGN  C element address, row-major.
- irq  out  1  level interrupt = done & irq_en.

## Operation

Registers (word offset = wbs_adr_i[3:2]):
- 0x0 CTRL: bit0 START (write-1 pulse, reads 0); bit1 IRQ_EN (R/W); bit2 ABORT (write-1 pulse, reads 0).
- 0x4 STATUS: bit0 BUSY (RO); bit1 DONE (sticky, write-1-clear); bit2 ABORTED (sticky, W1C).
- 0x8 CYCLES: [15:0] busy-cycle count of the last run (RO).
- 0xC: reads 0, writes ignored.

Wishbone rules:
- Access is selected when cyc & stb & adr[31:4]==BASE_ADDR[31:4].
- ack rises the cycle after select and lasts 1 cycle. It is never asserted two cycles in a row.
- Writes commit on the ack cycle.
- Out-of-window accesses get no ack.

FSM states: IDLE, CLR, ISSUE, DRAIN, WR.
- IDLE -> CLR: START write while IDLE. Clears DONE, ABORTED, CYCLES; i=j=k=0.
- CLR (1 cycle): mac_clr=1. -> ISSUE.
- ISSUE (N cycles): rd_en=1, a_addr=i*N+k, b_addr=k*N+j, k++. After k=N-1 -> DRAIN.
- DRAIN (1 cycle): no strobes issued (mac_en still high from the delay). -> WR.
- WR (1 cycle): res_we=1, res_addr=i*N+j. Advance j, then i. Last element (N-1,N-1) -> IDLE and set DONE; otherwise -> CLR.
- mac_en is rd_en delayed one register stage, matching the 1-cycle synchronous buffer read.
- Per element N+3 cycles; total N*N*(N+3) = 112 for N=4.
- CYCLES increments every cycle state != IDLE and saturates at 16'hFFFF.
- BUSY = (state != IDLE).

Boundary behaviour:
- START while busy: ignored.
- ABORT while busy: next state IDLE. All strobes low the following cycle, except the delayed mac_en, which may finish 1 cycle. Sets ABORTED; DONE is not set.
- ABORT while IDLE: ignored.
- START and ABORT in the same write: ABORT wins; no run starts.
- Reset mid-run: synchronous return to IDLE. All registers and outputs 0 (IRQ_EN=0).
- DONE W1C on the same cycle as DONE being set: set wins.

## Timing

- Reset values: wbs_ack_o=0, wbs_dat_o=0, rd_en=0, a_addr=0, b_addr=0, mac_clr=0, mac_en=0, res_we=0, res_addr=0, irq=0.
- All outputs are registered.
- START ack at cycle T: mac_clr at T+1; first rd_en at T+2.
- Last res_we at T+112 (N=4). DONE, BUSY=0 and irq (if enabled) are visible at T+113.

## Test plan

- Reset, then read 0x0/0x4/0x8 -> all read 0; ack exactly 1 cycle after stb each time.
- Write CTRL=0x3 (start, irq_en) -> mac_clr 1 cycle after ack. For element (1,2): a_addr=4,5,6,7, b_addr=2,6,10,14, then res_we with res_addr=6. DONE and irq high 113 cycles after ack; CYCLES=112.
- Write STATUS=0x2 after done -> DONE=0 and irq=0 next cycle. START written during a run -> run unaffected, still 112 cycles.
- Write ABORT at busy cycle 40 -> rd_en/res_we low from the next cycle; STATUS reads 0x4; irq stays 0; a subsequent START completes the full 112 cycles.
- Assert wb_rst_i during ISSUE -> every output 0 the next cycle; BUSY=0; IRQ_EN=0.
- Read at BASE_ADDR+0x20 -> no ack for 16 cycles. Write CTRL with sel=4'b1110 -> no effect.
